// File: rtl/smi_mem_lib_read_test_sequencer_64_if.sv
// Handshake bundle between the read-test sequencer, its run source, the burst checker and the result sink.
// The slave modport is the sequencer's view; the master modport is the view of everything around it.
interface smi_mem_lib_read_test_sequencer_64_if;
    logic        runValid;
    logic [63:0] runBaseAddr;
    logic [63:0] runAddrStride;
    logic [31:0] runBurstLen;
    logic [15:0] runBurstCount;
    logic [7:0]  runBurstOpts;
    logic [63:0] runDataInit;
    logic [63:0] runDataIncr;
    logic [63:0] runDataStep;
    logic        runStop;

    logic        testParamsValid;
    logic [63:0] testParamBurstAddr;
    logic [31:0] testParamBurstLen;
    logic [7:0]  testParamBurstOpts;
    logic [63:0] testParamDataInit;
    logic [63:0] testParamDataIncr;
    logic        testParamsStop;

    logic        testDoneValid;
    logic        testDoneStatusOk;
    logic        testDoneStop;

    logic        resultValid;
    logic        resultStatusOk;
    logic [15:0] resultPassCount;
    logic [15:0] resultFailCount;
    logic        resultStop;

    modport slave (
        input  runValid, runBaseAddr, runAddrStride, runBurstLen, runBurstCount,
               runBurstOpts, runDataInit, runDataIncr, runDataStep,
        output runStop,
        output testParamsValid, testParamBurstAddr, testParamBurstLen,
               testParamBurstOpts, testParamDataInit, testParamDataIncr,
        input  testParamsStop,
        input  testDoneValid, testDoneStatusOk,
        output testDoneStop,
        output resultValid, resultStatusOk, resultPassCount, resultFailCount,
        input  resultStop
    );

    modport master (
        output runValid, runBaseAddr, runAddrStride, runBurstLen, runBurstCount,
               runBurstOpts, runDataInit, runDataIncr, runDataStep,
        input  runStop,
        input  testParamsValid, testParamBurstAddr, testParamBurstLen,
               testParamBurstOpts, testParamDataInit, testParamDataIncr,
        output testParamsStop,
        output testDoneValid, testDoneStatusOk,
        input  testDoneStop,
        input  resultValid, resultStatusOk, resultPassCount, resultFailCount,
        output resultStop
    );
endinterface

// File: rtl/smi_mem_lib_read_test_sequencer_64.sv
// Read-test sequencer: turns one run request into a series of checker bursts and reports a pass/fail summary.
// Define SMI_MEM_TEST_ABORT_ON_FAIL_EN to end a run at the first failed burst.
module smi_mem_lib_read_test_sequencer_64 (
    input logic clk,
    input logic srst,
    smi_mem_lib_read_test_sequencer_64_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_t;

    state_t      r_state;
    logic        r_runStop;
    logic        r_paramsValid;
    logic        r_doneStop;
    logic        r_resultValid;

    logic [63:0] r_addr;
    logic [63:0] r_stride;
    logic [31:0] r_burstLen;
    logic [7:0]  r_burstOpts;
    logic [63:0] r_dataInit;
    logic [63:0] r_dataIncr;
    logic [63:0] r_dataStep;
    logic [15:0] r_remaining;
    logic [15:0] r_passCount;
    logic [15:0] r_failCount;

    logic w_runXfer;
    logic w_paramsXfer;
    logic w_doneXfer;
    logic w_resultXfer;
    logic w_endRun;

    // The stop/valid registers are only ever asserted in their own state, so they double as state qualifiers.
    assign w_runXfer    = bus.runValid && !r_runStop;
    assign w_paramsXfer = r_paramsValid && !bus.testParamsStop;
    assign w_doneXfer   = bus.testDoneValid && !r_doneStop;
    assign w_resultXfer = r_resultValid && !bus.resultStop;

`ifdef SMI_MEM_TEST_ABORT_ON_FAIL_EN
    assign w_endRun = (r_remaining == 16'd1) || !bus.testDoneStatusOk;
`else
    assign w_endRun = (r_remaining == 16'd1);
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state       <= S_IDLE;
            r_runStop     <= 1'b0;
            r_paramsValid <= 1'b0;
            r_doneStop    <= 1'b1;
            r_resultValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_runXfer) begin
                        r_runStop <= 1'b1;
                        if (bus.runBurstCount == 16'd0) begin
                            r_state       <= S_REPORT;
                            r_resultValid <= 1'b1;
                        end else begin
                            r_state       <= S_ISSUE;
                            r_paramsValid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_paramsXfer) begin
                        r_state       <= S_WAIT;
                        r_paramsValid <= 1'b0;
                        r_doneStop    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_doneXfer) begin
                        r_doneStop <= 1'b1;
                        if (w_endRun) begin
                            r_state       <= S_REPORT;
                            r_resultValid <= 1'b1;
                        end else begin
                            r_state       <= S_ISSUE;
                            r_paramsValid <= 1'b1;
                        end
                    end
                end
                S_REPORT: begin
                    if (w_resultXfer) begin
                        r_state       <= S_IDLE;
                        r_resultValid <= 1'b0;
                        r_runStop     <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_runStop     <= 1'b0;
                    r_paramsValid <= 1'b0;
                    r_doneStop    <= 1'b1;
                    r_resultValid <= 1'b0;
                end
            endcase
        end
    end

    // Datapath carries no reset; it is fully reloaded by the next accepted run.
    always_ff @(posedge clk) begin
        if (!srst) begin
            if (w_runXfer) begin
                r_addr      <= bus.runBaseAddr;
                r_stride    <= bus.runAddrStride;
                r_burstLen  <= bus.runBurstLen;
                r_burstOpts <= bus.runBurstOpts;
                r_dataInit  <= bus.runDataInit;
                r_dataIncr  <= bus.runDataIncr;
                r_dataStep  <= bus.runDataStep;
                r_remaining <= bus.runBurstCount;
                r_passCount <= 16'd0;
                r_failCount <= 16'd0;
            end
            if (w_paramsXfer) begin
                r_addr     <= r_addr + r_stride;
                r_dataInit <= r_dataInit + r_dataStep;
            end
            if (w_doneXfer) begin
                r_remaining <= r_remaining - 16'd1;
                if (bus.testDoneStatusOk) begin
                    r_passCount <= r_passCount + 16'd1;
                end else begin
                    r_failCount <= r_failCount + 16'd1;
                end
            end
        end
    end

    assign bus.runStop            = r_runStop;
    assign bus.testParamsValid    = r_paramsValid;
    assign bus.testParamBurstAddr = r_addr;
    assign bus.testParamBurstLen  = r_burstLen;
    assign bus.testParamBurstOpts = r_burstOpts;
    assign bus.testParamDataInit  = r_dataInit;
    assign bus.testParamDataIncr  = r_dataIncr;
    assign bus.testDoneStop       = r_doneStop;
    assign bus.resultValid        = r_resultValid;
    assign bus.resultStatusOk     = (r_failCount == 16'd0);
    assign bus.resultPassCount    = r_passCount;
    assign bus.resultFailCount    = r_failCount;
endmodule

// File: tb/tb_smi_mem_lib_read_test_sequencer_64.sv
// Directed bench for the read-test sequencer: run issue, zero-count runs, failures, wrap, stalls and mid-run reset.
module tb_smi_mem_lib_read_test_sequencer_64;
    logic clk;
    logic srst;
    int   n_assert;
    int   n_fail;

    smi_mem_lib_read_test_sequencer_64_if bus ();

    smi_mem_lib_read_test_sequencer_64 dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [63:0] base, input logic [63:0] stride, input logic [31:0] len,
                             input logic [15:0] cnt, input logic [63:0] init, input logic [63:0] step);
        bus.runBaseAddr   = base;
        bus.runAddrStride = stride;
        bus.runBurstLen   = len;
        bus.runBurstCount = cnt;
        bus.runBurstOpts  = 8'hA5;
        bus.runDataInit   = init;
        bus.runDataIncr   = 64'd1;
        bus.runDataStep   = step;
        bus.runValid      = 1'b1;
        for (int k = 0; k < 20 && bus.runStop; k++) tick();
        chk("run_accept_ready", bus.runStop, 1'b0);
        tick();
        bus.runValid = 1'b0;
    endtask

    task automatic serve_burst(input logic [63:0] exp_addr, input logic [63:0] exp_init, input logic ok);
        for (int k = 0; k < 20 && !bus.testParamsValid; k++) tick();
        chk("params_valid", bus.testParamsValid, 1'b1);
        chk("burst_addr", bus.testParamBurstAddr, exp_addr);
        chk("burst_init", bus.testParamDataInit, exp_init);
        tick();
        bus.testDoneValid    = 1'b1;
        bus.testDoneStatusOk = ok;
        for (int k = 0; k < 20 && bus.testDoneStop; k++) tick();
        chk("done_ready", bus.testDoneStop, 1'b0);
        tick();
        bus.testDoneValid = 1'b0;
    endtask

    task automatic finish_result(input logic [15:0] pass, input logic [15:0] fail, input logic ok);
        for (int k = 0; k < 20 && !bus.resultValid; k++) tick();
        chk("result_valid", bus.resultValid, 1'b1);
        chk("params_quiet_in_report", bus.testParamsValid, 1'b0);
        chk("pass_count", bus.resultPassCount, pass);
        chk("fail_count", bus.resultFailCount, fail);
        chk("status_ok", bus.resultStatusOk, ok);
        tick();
        chk("result_dropped", bus.resultValid, 1'b0);
        chk("idle_ready", bus.runStop, 1'b0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        srst = 1'b1;
        bus.runValid = 1'b0;
        bus.runBaseAddr = '0;
        bus.runAddrStride = '0;
        bus.runBurstLen = '0;
        bus.runBurstCount = '0;
        bus.runBurstOpts = '0;
        bus.runDataInit = '0;
        bus.runDataIncr = '0;
        bus.runDataStep = '0;
        bus.testParamsStop = 1'b0;
        bus.testDoneValid = 1'b0;
        bus.testDoneStatusOk = 1'b0;
        bus.resultStop = 1'b0;
        tick();
        tick();
        srst = 1'b0;

        chk("rst_runStop", bus.runStop, 1'b0);
        chk("rst_paramsValid", bus.testParamsValid, 1'b0);
        chk("rst_doneStop", bus.testDoneStop, 1'b1);
        chk("rst_resultValid", bus.resultValid, 1'b0);

        // Three passing bursts, parameters one cycle after the run transfer
        start_run(64'h1000, 64'h200, 32'd16, 16'd3, 64'd0, 64'd16);
        chk("params_latency", bus.testParamsValid, 1'b1);
        chk("run_busy", bus.runStop, 1'b1);
        chk("burst_len", bus.testParamBurstLen, 32'd16);
        chk("burst_opts", bus.testParamBurstOpts, 8'hA5);
        chk("burst_incr", bus.testParamDataIncr, 64'd1);
        serve_burst(64'h1000, 64'd0, 1'b1);
        serve_burst(64'h1200, 64'd16, 1'b1);
        serve_burst(64'h1400, 64'd32, 1'b1);
        finish_result(16'd3, 16'd0, 1'b1);

        // Zero-length run goes straight to the summary
        start_run(64'h0, 64'h10, 32'd4, 16'd0, 64'd7, 64'd1);
        chk("zero_no_params", bus.testParamsValid, 1'b0);
        finish_result(16'd0, 16'd0, 1'b1);

        // Second of four bursts fails
        start_run(64'h2000, 64'h40, 32'd8, 16'd4, 64'd100, 64'd8);
        serve_burst(64'h2000, 64'd100, 1'b1);
        serve_burst(64'h2040, 64'd108, 1'b0);
`ifdef SMI_MEM_TEST_ABORT_ON_FAIL_EN
        finish_result(16'd1, 16'd1, 1'b0);
`else
        serve_burst(64'h2080, 64'd116, 1'b1);
        serve_burst(64'h20C0, 64'd124, 1'b1);
        finish_result(16'd3, 16'd1, 1'b0);
`endif

        // Address and init wrap modulo 2^64
        start_run(64'hFFFF_FFFF_FFFF_FF00, 64'h100, 32'd2, 16'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        serve_burst(64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        serve_burst(64'h0, 64'd1, 1'b1);
        finish_result(16'd2, 16'd0, 1'b1);

        // Backpressure on params and result; stray failing results during Issue are ignored
        bus.testParamsStop = 1'b1;
        start_run(64'h40, 64'h8, 32'd1, 16'd1, 64'd5, 64'd1);
        bus.testDoneValid    = 1'b1;
        bus.testDoneStatusOk = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_params_valid", bus.testParamsValid, 1'b1);
            chk("stall_addr", bus.testParamBurstAddr, 64'h40);
            chk("stall_done_stop", bus.testDoneStop, 1'b1);
            tick();
        end
        bus.testDoneValid  = 1'b0;
        bus.testParamsStop = 1'b0;
        serve_burst(64'h40, 64'd5, 1'b1);
        bus.resultStop = 1'b1;
        for (int k = 0; k < 20 && !bus.resultValid; k++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_result_valid", bus.resultValid, 1'b1);
            chk("hold_pass", bus.resultPassCount, 16'd1);
            chk("hold_fail", bus.resultFailCount, 16'd0);
            chk("hold_run_busy", bus.runStop, 1'b1);
            tick();
        end
        bus.resultStop = 1'b0;
        finish_result(16'd1, 16'd0, 1'b1);

        // Reset while waiting on a result abandons the run
        start_run(64'h3000, 64'h100, 32'd4, 16'd3, 64'd0, 64'd4);
        for (int k = 0; k < 20 && !bus.testParamsValid; k++) tick();
        tick();
        chk("in_wait", bus.testDoneStop, 1'b0);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("mid_rst_runStop", bus.runStop, 1'b0);
        chk("mid_rst_doneStop", bus.testDoneStop, 1'b1);
        chk("mid_rst_paramsValid", bus.testParamsValid, 1'b0);
        chk("mid_rst_resultValid", bus.resultValid, 1'b0);
        start_run(64'h5000, 64'h20, 32'd4, 16'd2, 64'd9, 64'd3);
        serve_burst(64'h5000, 64'd9, 1'b1);
        serve_burst(64'h5020, 64'd12, 1'b0);
        finish_result(16'd1, 16'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/smi_mem_lib_read_test_sequencer_64.md
SMI_MEM_LIB_READ_TEST_SEQUENCER_64 -- requirements
Module: smi_mem_lib_read_test_sequencer_64

Interface
REQ-001 The block SHALL use reset srst, synchronous, active-high, and clock clk.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 srst  in  1  synchronous active-high reset.
REQ-004 runValid  in  1  run request valid.
REQ-005 runBaseAddr  in  64  address of first burst.
REQ-006 runAddrStride  in  64  address increment between bursts.
REQ-007 runBurstLen  in  32  beats per burst, nonzero.
REQ-008 runBurstCount  in  16  number of bursts in run.
REQ-009 runBurstOpts  in  8  burst options forwarded unchanged.
REQ-010 runDataInit  in  64  expected first data value of first burst.
REQ-011 runDataIncr  in  64  per-beat data increment forwarded unchanged.
REQ-012 runDataStep  in  64  data-init increment between bursts.
REQ-013 runStop  out  1  run request backpressure.
REQ-014 testParamsValid  out  1  checker parameter set valid.
REQ-015 testParamBurstAddr  out  64  current burst address.
REQ-016 testParamBurstLen  out  32  captured runBurstLen.
REQ-017 testParamBurstOpts  out  8  captured runBurstOpts.
REQ-018 testParamDataInit  out  64  current burst expected init value.
REQ-019 testParamDataIncr  out  64  captured runDataIncr.
REQ-020 testParamsStop  in  1  checker parameter backpressure.
REQ-021 testDoneValid  in  1  checker burst result valid.
REQ-022 testDoneStatusOk  in  1  checker burst passed.
REQ-023 testDoneStop  out  1  checker result backpressure.
REQ-024 resultValid  out  1  run summary valid.
REQ-025 resultStatusOk  out  1  high when resultFailCount is zero.
REQ-026 resultPassCount  out  16  bursts reported ok.
REQ-027 resultFailCount  out  16  bursts reported failed.
REQ-028 resultStop  in  1  summary backpressure.

Function
REQ-029 All handshakes SHALL transfer on a cycle with valid high and stop low; valid held until transfer.
REQ-030 States SHALL be Idle, Issue, Wait, Report; only Idle drives runStop low, only Issue drives testParamsValid high, only Wait drives testDoneStop low, only Report drives resultValid high.
REQ-031 Idle: on run transfer SHALL capture all run fields, clear both counts, set remaining=runBurstCount; next state Issue, or Report if runBurstCount==0.
REQ-032 testParamsValid SHALL assert the cycle after run transfer (1-cycle latency).
REQ-033 Issue: on transfer SHALL add runAddrStride to address and runDataStep to data init (64-bit modulo wrap) and enter Wait.
REQ-034 Wait: on result transfer SHALL increment resultPassCount if testDoneStatusOk else resultFailCount, decrement remaining; enter Report when remaining was 1, else Issue.
REQ-035 Report: on transfer SHALL return to Idle; a new run is accepted no earlier than the following cycle.
REQ-036 Counts SHALL not overflow since pass+fail never exceeds runBurstCount (max 65535).
REQ-037 testDoneValid outside Wait SHALL be ignored and not counted.

Reset
REQ-038 srst SHALL force Idle on the next edge, including mid-run, discarding the run; afterwards runStop=0, testParamsValid=0, testDoneStop=1, resultValid=0; datapath registers are not reset.

Configuration
REQ-039 With SMI_MEM_TEST_ABORT_ON_FAIL_EN defined, a failed burst result SHALL enter Report immediately, remaining bursts skipped; without it all runBurstCount bursts SHALL be issued regardless of failures.

Verification
REQ-040 base 0x1000, stride 0x200, len 16, count 3, init 0, step 16, all pass -> addrs 0x1000/0x1200/0x1400, inits 0/16/32, pass=3 fail=0 statusOk=1.
REQ-041 count 0 -> no testParamsValid, resultValid within 2 cycles, pass=0 fail=0 statusOk=1.
REQ-042 count 4, burst 2 fails -> pass=3 fail=1 statusOk=0; with ABORT macro pass=1 fail=1, only 2 bursts issued.
REQ-043 base 0xFFFFFFFFFFFFFF00, stride 0x100, count 2 -> second address 0x0.
REQ-044 testParamsStop and resultStop held high 5 cycles -> outputs stable, no extra issues, counts unchanged.
REQ-045 srst asserted in Wait -> Idle next cycle, runStop=0, testDoneStop=1, new run completes correctly.
